// File: rtl/pc_flow_ctrl_if.sv
// Bundle of the pipeline-control signals exchanged between the core datapath
// (master) and the PC / pipeline-register flow controller (slave).
//
// Handshake: the host request is a level handshake. ecall_req stays high
// until the host raises ecall_ack for at least one cycle. ecall_ack is only
// observed while the request is outstanding. Every other signal here is a
// per-cycle level with no valid/ready pairing.
interface pc_flow_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             imem_ready;
    logic             branch_ID;
    logic             jump_ID;
    logic             pred_taken;
    logic             branch_EX;
    logic             outcome_EX;
    logic             pred_EX;
    logic             load_use;
    logic             ecall_ID;
    logic             ecall_ack;
    logic             cnt_clr;
    logic [1:0]       pc_sel;
    logic             pc_we;
    logic             stall_IF_ID;
    logic             flush_IF_ID;
    logic             flush_ID_EX;
    logic             ecall_req;
    logic             halted;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic [1:0]       state_dbg;

    modport master (
        output imem_ready, branch_ID, jump_ID, pred_taken, branch_EX,
               outcome_EX, pred_EX, load_use, ecall_ID, ecall_ack, cnt_clr,
        input  pc_sel, pc_we, stall_IF_ID, flush_IF_ID, flush_ID_EX,
               ecall_req, halted, branch_cnt, mispred_cnt, state_dbg
    );

    modport slave (
        input  imem_ready, branch_ID, jump_ID, pred_taken, branch_EX,
               outcome_EX, pred_EX, load_use, ecall_ID, ecall_ack, cnt_clr,
        output pc_sel, pc_we, stall_IF_ID, flush_IF_ID, flush_ID_EX,
               ecall_req, halted, branch_cnt, mispred_cnt, state_dbg
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// PC-source / stall / flush sequencer for the 5-stage core.
// It also runs the ecall drain-request-resume handshake with the host
// and keeps saturating branch and mispredict counters.
module pc_flow_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic         clk,
    input  logic         reset,
    pc_flow_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DRAIN  = 2'd1,
        S_REQ    = 2'd2,
        S_RESUME = 2'd3
    } state_t;

    localparam logic [3:0]       DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           state_q, state_d;
    logic [3:0]       drain_q, drain_d;
    logic             ecall_req_q;
    logic             halted_q;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_q;

    logic [1:0] pc_sel;
    logic       pc_we;
    logic       stall_if_id;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       mispredict;

    assign mispredict = bus.branch_EX & (bus.outcome_EX ^ bus.pred_EX);

    // Next state and Mealy pipeline controls; idle (hold PC) while reset is low.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_sel      = 2'b11;
        pc_we       = 1'b0;
        stall_if_id = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (reset) begin
            case (state_q)
                S_RUN: begin
                    if (mispredict) begin
                        pc_sel      = 2'b10;
                        pc_we       = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (bus.ecall_ID) begin
                        flush_if_id = 1'b1;
                        state_d     = S_DRAIN;
                        drain_d     = DRAIN_LOAD;
                    end else if (bus.load_use) begin
                        stall_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                    end else if (!bus.imem_ready) begin
                        flush_if_id = 1'b1;
                    end else if (bus.jump_ID || (bus.branch_ID && bus.pred_taken)) begin
                        pc_sel      = 2'b01;
                        pc_we       = 1'b1;
                        flush_if_id = 1'b1;
                    end else begin
                        pc_sel = 2'b00;
                        pc_we  = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (mispredict) begin
                        // The ecall sat on the wrong path: abandon it and redirect.
                        pc_sel      = 2'b10;
                        pc_we       = 1'b1;
                        flush_if_id = 1'b1;
                        flush_id_ex = 1'b1;
                        state_d     = S_RUN;
                    end else begin
                        flush_if_id = 1'b1;
                        if (drain_q == 4'd0) begin
                            state_d = S_REQ;
                        end else begin
                            drain_d = drain_q - 4'd1;
                        end
                    end
                end
                S_REQ: begin
                    flush_if_id = 1'b1;
                    if (bus.ecall_ack) begin
                        state_d = S_RESUME;
                    end
                end
                S_RESUME: begin
                    // Step the PC past the ecall.
                    pc_sel  = 2'b00;
                    pc_we   = 1'b1;
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_RUN;
                end
            endcase
        end
    end

    // FSM state, drain counter and the registered host-facing flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_RUN;
            drain_q     <= 4'd0;
            ecall_req_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            ecall_req_q <= (state_d == S_REQ);
            halted_q    <= (state_d != S_RUN);
        end
    end

    // Saturating performance counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (bus.branch_EX) begin
            if (branch_cnt_q != CNT_MAX) begin
                branch_cnt_q <= branch_cnt_q + 1'b1;
            end
            if (mispredict && (mispred_cnt_q != CNT_MAX)) begin
                mispred_cnt_q <= mispred_cnt_q + 1'b1;
            end
        end
    end

    assign bus.pc_sel      = pc_sel;
    assign bus.pc_we       = pc_we;
    assign bus.stall_IF_ID = stall_if_id;
    assign bus.flush_IF_ID = flush_if_id;
    assign bus.flush_ID_EX = flush_id_ex;
    assign bus.ecall_req   = ecall_req_q;
    assign bus.halted      = halted_q;
    assign bus.branch_cnt  = branch_cnt_q;
    assign bus.mispred_cnt = mispred_cnt_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed scenarios followed by a random stream,
// all checked against a behavioural model of the control rules.
module tb_pc_flow_ctrl;
    localparam int DRAIN_CYCLES = 3;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0] sel;
        logic       we;
        logic       stall;
        logic       fif;
        logic       fid;
    } ctl_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_flow_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pc_flow_ctrl #(
        .DRAIN_CYCLES(DRAIN_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- reference model ----------------
    // Ecall progress: draining (with cycles still to go), waiting on the host,
    // or taking the single step past the ecall.
    bit m_draining;
    int m_drain_left;
    bit m_waiting_host;
    bit m_stepping;
    int m_bcnt;
    int m_mcnt;

    task automatic model_reset();
        m_draining     = 1'b0;
        m_drain_left   = 0;
        m_waiting_host = 1'b0;
        m_stepping     = 1'b0;
        m_bcnt         = 0;
        m_mcnt         = 0;
    endtask

    function automatic bit model_mispredict();
        return bus.branch_EX && (bus.outcome_EX != bus.pred_EX);
    endfunction

    function automatic ctl_t redirect_ctl();
        ctl_t c;
        c = '{sel: 2'd2, we: 1'b1, stall: 1'b0, fif: 1'b1, fid: 1'b1};
        return c;
    endfunction

    function automatic ctl_t expect_ctl();
        ctl_t c;
        c = '{sel: 2'd3, we: 1'b0, stall: 1'b0, fif: 1'b0, fid: 1'b0};
        if (!reset) return c;
        if (m_waiting_host) begin
            c.fif = 1'b1;
        end else if (m_stepping) begin
            c.sel = 2'd0;
            c.we  = 1'b1;
        end else if (m_draining) begin
            if (model_mispredict()) c = redirect_ctl();
            else                    c.fif = 1'b1;
        end else if (model_mispredict()) begin
            c = redirect_ctl();
        end else if (bus.ecall_ID) begin
            c.fif = 1'b1;
        end else if (bus.load_use) begin
            c.stall = 1'b1;
            c.fid   = 1'b1;
        end else if (!bus.imem_ready) begin
            c.fif = 1'b1;
        end else if (bus.jump_ID || (bus.branch_ID && bus.pred_taken)) begin
            c.sel = 2'd1;
            c.we  = 1'b1;
            c.fif = 1'b1;
        end else begin
            c.sel = 2'd0;
            c.we  = 1'b1;
        end
        return c;
    endfunction

    // Advance the model across the coming rising edge.
    task automatic model_step();
        bit mp;
        if (!reset) begin
            model_reset();
            return;
        end
        mp = model_mispredict();
        if (bus.cnt_clr) begin
            m_bcnt = 0;
            m_mcnt = 0;
        end else if (bus.branch_EX) begin
            if (m_bcnt < CNT_MAX) m_bcnt++;
            if (mp && m_mcnt < CNT_MAX) m_mcnt++;
        end
        if (m_waiting_host) begin
            if (bus.ecall_ack) begin
                m_waiting_host = 1'b0;
                m_stepping     = 1'b1;
            end
        end else if (m_stepping) begin
            m_stepping = 1'b0;
        end else if (m_draining) begin
            if (mp) begin
                m_draining = 1'b0;
            end else if (m_drain_left == 0) begin
                m_draining     = 1'b0;
                m_waiting_host = 1'b1;
            end else begin
                m_drain_left--;
            end
        end else if (!mp && bus.ecall_ID) begin
            m_draining   = 1'b1;
            m_drain_left = DRAIN_CYCLES - 1;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle_check(input string tag);
        ctl_t e;
        #1;
        e = expect_ctl();
        check({tag, ".pc_sel"},      32'(bus.pc_sel),      32'(e.sel));
        check({tag, ".pc_we"},       32'(bus.pc_we),       32'(e.we));
        check({tag, ".stall_IF_ID"}, 32'(bus.stall_IF_ID), 32'(e.stall));
        check({tag, ".flush_IF_ID"}, 32'(bus.flush_IF_ID), 32'(e.fif));
        check({tag, ".flush_ID_EX"}, 32'(bus.flush_ID_EX), 32'(e.fid));
        check({tag, ".ecall_req"},   32'(bus.ecall_req),   32'(m_waiting_host));
        check({tag, ".halted"},      32'(bus.halted),
              32'(m_draining || m_waiting_host || m_stepping));
        check({tag, ".branch_cnt"},  32'(bus.branch_cnt),  32'(m_bcnt));
        check({tag, ".mispred_cnt"}, 32'(bus.mispred_cnt), 32'(m_mcnt));
        model_step();
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        bus.imem_ready = 1'b1;
        bus.branch_ID  = 1'b0;
        bus.jump_ID    = 1'b0;
        bus.pred_taken = 1'b0;
        bus.branch_EX  = 1'b0;
        bus.outcome_EX = 1'b0;
        bus.pred_EX    = 1'b0;
        bus.load_use   = 1'b0;
        bus.ecall_ID   = 1'b0;
        bus.ecall_ack  = 1'b0;
        bus.cnt_clr    = 1'b0;
    endtask

    task automatic next();
        @(negedge clk);
        idle_inputs();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();

        // Reset held low: PC held, everything quiet.
        for (int i = 0; i < 3; i++) begin
            next();
            cycle_check("reset");
        end

        // Release; no events.
        next();
        reset = 1'b1;
        cycle_check("run_idle");
        check("run_idle.sel_const", 32'(bus.pc_sel), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next();
            cycle_check("run_idle");
        end

        // Predicted-taken branch, then it mispredicts two cycles later.
        next(); bus.branch_ID = 1'b1; bus.pred_taken = 1'b1;
        cycle_check("br_pred");
        check("br_pred.sel_const", 32'(bus.pc_sel), 32'd1);
        next();
        cycle_check("br_gap");
        next(); bus.branch_EX = 1'b1; bus.outcome_EX = 1'b0; bus.pred_EX = 1'b1;
        cycle_check("mispred");
        next();
        cycle_check("after_mispred");
        check("after_mispred.branch_cnt_const", 32'(bus.branch_cnt), 32'd1);
        check("after_mispred.mispred_cnt_const", 32'(bus.mispred_cnt), 32'd1);

        // Mispredict outranks load-use; then load-use alone.
        next(); bus.load_use = 1'b1; bus.branch_EX = 1'b1; bus.outcome_EX = 1'b1; bus.pred_EX = 1'b0;
        cycle_check("lu_mp");
        check("lu_mp.stall_const", 32'(bus.stall_IF_ID), 32'd0);
        next(); bus.load_use = 1'b1;
        cycle_check("lu_only");
        check("lu_only.stall_const", 32'(bus.stall_IF_ID), 32'd1);

        // Full ecall: drain, request, ack after five cycles, resume.
        next(); bus.ecall_ID = 1'b1;
        cycle_check("ecall");
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            next();
            cycle_check("drain");
            check("drain.halted_const", 32'(bus.halted), 32'd1);
            check("drain.req_const", 32'(bus.ecall_req), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            next();
            cycle_check("req_wait");
            check("req_wait.req_const", 32'(bus.ecall_req), 32'd1);
        end
        next(); bus.ecall_ack = 1'b1;
        cycle_check("req_ack");
        next();
        cycle_check("resume");
        check("resume.we_const", 32'(bus.pc_we), 32'd1);
        check("resume.halted_const", 32'(bus.halted), 32'd1);
        next();
        cycle_check("back_run");
        check("back_run.halted_const", 32'(bus.halted), 32'd0);
        check("back_run.req_const", 32'(bus.ecall_req), 32'd0);

        // Ecall aborted by a mispredict in the second drain cycle.
        next(); bus.ecall_ID = 1'b1;
        cycle_check("ab_ecall");
        next();
        cycle_check("ab_drain1");
        next(); bus.branch_EX = 1'b1; bus.outcome_EX = 1'b1; bus.pred_EX = 1'b0;
        cycle_check("ab_mispred");
        check("ab_mispred.sel_const", 32'(bus.pc_sel), 32'd2);
        for (int i = 0; i < 4; i++) begin
            next();
            cycle_check("ab_run");
            check("ab_run.halted_const", 32'(bus.halted), 32'd0);
            check("ab_run.req_const", 32'(bus.ecall_req), 32'd0);
        end

        // Asynchronous reset while the host request is outstanding.
        next(); bus.ecall_ID = 1'b1;
        cycle_check("ar_ecall");
        for (int i = 0; i < DRAIN_CYCLES + 1; i++) begin
            next();
            cycle_check("ar_pre");
        end
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        #1;
        check("async_rst.ecall_req", 32'(bus.ecall_req), 32'd0);
        check("async_rst.halted", 32'(bus.halted), 32'd0);
        check("async_rst.pc_sel", 32'(bus.pc_sel), 32'd3);
        check("async_rst.pc_we", 32'(bus.pc_we), 32'd0);
        model_reset();
        next();
        cycle_check("rst_hold");
        next(); reset = 1'b1;
        cycle_check("rst_rel");

        // Counter saturation and clear priority.
        next(); bus.cnt_clr = 1'b1;
        cycle_check("sat_clr");
        for (int i = 0; i < 20; i++) begin
            next();
            bus.branch_EX  = 1'b1;
            bus.pred_EX    = 1'b1;
            bus.outcome_EX = (i % 3 != 0);
            cycle_check("sat");
        end
        next();
        cycle_check("sat_end");
        check("sat_end.branch_cnt_const", 32'(bus.branch_cnt), 32'd15);
        next(); bus.cnt_clr = 1'b1; bus.branch_EX = 1'b1; bus.outcome_EX = 1'b1; bus.pred_EX = 1'b0;
        cycle_check("clr_pri");
        next();
        cycle_check("after_clr");
        check("after_clr.branch_cnt_const", 32'(bus.branch_cnt), 32'd0);
        check("after_clr.mispred_cnt_const", 32'(bus.mispred_cnt), 32'd0);

        // Random stream.
        for (int i = 0; i < 400; i++) begin
            next();
            bus.imem_ready = ($urandom_range(0, 7) != 0);
            bus.branch_ID  = ($urandom_range(0, 3) == 0);
            bus.jump_ID    = ($urandom_range(0, 7) == 0);
            bus.pred_taken = 1'($urandom_range(0, 1));
            bus.branch_EX  = ($urandom_range(0, 2) == 0);
            bus.outcome_EX = 1'($urandom_range(0, 1));
            bus.pred_EX    = 1'($urandom_range(0, 1));
            bus.load_use   = ($urandom_range(0, 5) == 0);
            bus.ecall_ID   = ($urandom_range(0, 11) == 0);
            bus.ecall_ack  = ($urandom_range(0, 3) == 0);
            bus.cnt_clr    = ($urandom_range(0, 40) == 0);
            cycle_check("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
